// File: rtl/btn_debounce.sv
// btn_debounce: synchronized, debounced pushbutton with press/release/hold pulses.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state, state_nx;
  logic s1, btn_s;
  logic [DW-1:0] db_cnt, db_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic hold_done, done_nx, hold_fire;
  always_comb begin
    state_nx = state;
    db_nx = db_cnt;
    hold_nx = hold_cnt;
    done_nx = hold_done;
    hold_fire = state == PRESSED && !hold_done && hold_cnt == HOLD_MAX;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nx = PRESS_WAIT;
          db_nx = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nx = IDLE;
          db_nx = '0;
        end else if (db_cnt == DB_MAX) begin
          state_nx = PRESSED;
          hold_nx = '0;
          done_nx = 1'b0;
        end else db_nx = db_cnt + DW'(1);
      end
      PRESSED: begin
        // hold counter saturates at its terminal value; hold_done blocks repeats
        hold_nx = hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + HW'(1);
        done_nx = hold_done | hold_fire;
        if (!btn_s) begin
          state_nx = RELEASE_WAIT;
          db_nx = '0;
        end
      end
      default: begin
        if (btn_s) begin
          state_nx = PRESSED;
          db_nx = '0;
        end else if (db_cnt == DB_MAX) state_nx = IDLE;
        else db_nx = db_cnt + DW'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      btn_s <= 1'b0;
      state <= IDLE;
      db_cnt <= '0;
      hold_cnt <= '0;
      hold_done <= 1'b0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
      btn_release <= 1'b0;
      btn_hold <= 1'b0;
    end else begin
      s1 <= btn_in;
      btn_s <= s1;
      state <= state_nx;
      db_cnt <= db_nx;
      hold_cnt <= hold_nx;
      hold_done <= done_nx;
      btn_level <= state_nx == PRESSED || state_nx == RELEASE_WAIT;
      btn_press <= state == PRESS_WAIT && state_nx == PRESSED;
      btn_release <= state == RELEASE_WAIT && state_nx == IDLE;
      btn_hold <= hold_fire;
    end
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios with hand-computed pulse edges, checked every cycle.
module tb_btn_debounce;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level, btn_press, btn_release, btn_hold;
  int n_chk = 0;
  int n_err = 0;
  bit pat[$];
  int rst_at;
  int ep[2], eh[2], er[2], tg[3];

  btn_debounce #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_hold(btn_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic hit(input int a[2], input int t);
    return a[0] == t || a[1] == t;
  endfunction

  function automatic logic lvl(input int t);
    logic v = 1'b0;
    for (int i = 0; i < 3; i++) if (tg[i] >= 0 && tg[i] <= t) v = ~v;
    return v;
  endfunction

  task automatic add(input bit b, input int n);
    for (int i = 0; i < n; i++) pat.push_back(b);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    btn_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({name, " rst outs"}, {btn_level, btn_press, btn_release, btn_hold}, 4'b0);
    rst_n = 1'b1;
    pat.delete();
    rst_at = -1;
  endtask

  task automatic run(input string name);
    for (int t = 0; t < pat.size(); t++) begin
      rst_n = t == rst_at ? 1'b0 : 1'b1;
      btn_in = pat[t];
      @(posedge clk);
      #1;
      chk($sformatf("%s level@%0d", name, t), btn_level, lvl(t));
      chk($sformatf("%s press@%0d", name, t), btn_press, hit(ep, t));
      chk($sformatf("%s release@%0d", name, t), btn_release, hit(er, t));
      chk($sformatf("%s hold@%0d", name, t), btn_hold, hit(eh, t));
    end
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset("clean");
    add(1, 30); add(0, 12);
    ep = '{6, -1}; eh = '{16, -1}; er = '{36, -1}; tg = '{6, 36, -1};
    run("clean");

    do_reset("bouncy");
    add(1, 2); add(0, 2); add(1, 2); add(0, 2); add(1, 20); add(0, 10);
    ep = '{14, -1}; eh = '{24, -1}; er = '{34, -1}; tg = '{14, 34, -1};
    run("bouncy");

    do_reset("short");
    add(1, 3); add(0, 12);
    ep = '{-1, -1}; eh = '{-1, -1}; er = '{-1, -1}; tg = '{-1, -1, -1};
    run("short");

    do_reset("reldip");
    add(1, 20); add(0, 2); add(1, 8); add(0, 10);
    ep = '{6, -1}; eh = '{16, -1}; er = '{36, -1}; tg = '{6, 36, -1};
    run("reldip");

    do_reset("freeze");
    add(1, 10); add(0, 2); add(1, 18); add(0, 10);
    ep = '{6, -1}; eh = '{18, -1}; er = '{36, -1}; tg = '{6, 36, -1};
    run("freeze");

    do_reset("rstmid");
    add(1, 45);
    rst_at = 20;
    ep = '{6, 27}; eh = '{16, 37}; er = '{-1, -1}; tg = '{6, 20, 27};
    run("rstmid");

    do_reset("rstpulse");
    add(1, 30);
    rst_at = 6;
    ep = '{13, -1}; eh = '{23, -1}; er = '{-1, -1}; tg = '{13, -1, -1};
    run("rstpulse");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
